// File: rtl/mod5_stream_acc_pkg.sv
// Shared constants and residue arithmetic for the mod-5 streaming accumulator.
// Relies on 2^32 = 1 (mod 5) and 16 = 1 (mod 5).
package mod5_stream_acc_pkg;

    localparam int RES_W  = 3;
    localparam int MOD    = 5;
    localparam int WORD_W = 32;

    // (a + b) mod 5 for a, b already reduced to 0..4
    function automatic logic [RES_W-1:0] mod5_add(input logic [RES_W-1:0] a,
                                                  input logic [RES_W-1:0] b);
        logic [RES_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'd5) begin
            mod5_add = RES_W'(sum - 4'd5);
        end else begin
            mod5_add = sum[RES_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mod5_stream_acc_word_res5.sv
// Combinational 32-bit mod-5 residue: since 16 = 1 (mod 5), the word residue
// equals the sum of its hex-nibble residues mod 5.
module word_res5
    import mod5_stream_acc_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [RES_W-1:0]  res
);

    function automatic logic [RES_W-1:0] nib_mod5(input logic [3:0] n);
        if (n >= 4'd10) begin
            nib_mod5 = RES_W'(n - 4'd10);
        end else if (n >= 4'd5) begin
            nib_mod5 = RES_W'(n - 4'd5);
        end else begin
            nib_mod5 = n[RES_W-1:0];
        end
    endfunction

    logic [RES_W-1:0] acc_s;

    // Fold the eight nibble residues into one word residue
    always_comb begin
        acc_s = 3'd0;
        for (int i = 0; i < WORD_W / 4; i++) begin
            acc_s = mod5_add(acc_s, nib_mod5(word[4*i +: 4]));
        end
    end

    assign res = acc_s;

endmodule

// File: rtl/mod5_stream_acc.sv
// Streaming mod-5 accumulator over multi-word messages (MS word first), with
// a one-word input stage and a registered result slot, valid/ready both sides.
module mod5_stream_acc
    import mod5_stream_acc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_res,
    output logic [CNT_W-1:0]   out_words
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              s1_valid_r;
    logic [WORD_W-1:0] s1_data_r;
    logic              s1_last_r;
    logic [RES_W-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              out_valid_r;
    logic [RES_W-1:0]  out_res_r;
    logic [CNT_W-1:0]  out_words_r;

    logic              s1_fire_s;
    logic              in_fire_s;
    logic [RES_W-1:0]  w_res_s;
    logic [RES_W-1:0]  acc_next_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    word_res5 u_word_res5 (
        .word (s1_data_r),
        .res  (w_res_s)
    );

    // A last word only stalls when the result slot is full and not draining
    assign s1_fire_s  = s1_valid_r && (!s1_last_r || !out_valid_r || out_ready);
    assign in_ready   = !s1_valid_r || s1_fire_s;
    assign in_fire_s  = in_valid && in_ready;
    assign acc_next_s = mod5_add(acc_r, w_res_s);
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

    // Stage-1 word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 32'd0;
            s1_last_r  <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= in_data;
            s1_last_r  <= in_last;
        end else if (s1_fire_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Running message residue and saturating word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= 3'd0;
            cnt_r <= '0;
        end else if (s1_fire_s) begin
            if (s1_last_r) begin
                acc_r <= 3'd0;
                cnt_r <= '0;
            end else begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_inc_s;
            end
        end
    end

    // Result slot: a new result may replace a draining one in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_res_r   <= 3'd0;
            out_words_r <= '0;
        end else if (s1_fire_s && s1_last_r) begin
            out_valid_r <= 1'b1;
            out_res_r   <= acc_next_s;
            out_words_r <= cnt_inc_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_words = out_words_r;

endmodule

// File: tb/tb_mod5_stream_acc.sv
// Directed self-checking bench for mod5_stream_acc, including a CNT_W=2
// instance for counter saturation.
module tb_mod5_stream_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_res;
    logic [15:0] out_words;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic        s_in_last;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [2:0]  s_out_res;
    logic [1:0]  s_out_words;

    int n_checks;
    int n_fail;

    mod5_stream_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_words (out_words)
    );

    mod5_stream_acc #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_res   (s_out_res),
        .out_words (s_out_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_res !== 3'd0 || out_words !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b res=%0d words=%0d, want 0/0/0", out_valid, out_res, out_words);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_single_word(input logic [31:0] w, input logic [2:0] exp_res, input string name);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %0b, want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF; in_last = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early_valid: got %0b, want 0", name, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== exp_res || out_words !== 16'd1) begin
            n_fail++;
            $display("FAIL %s_result: got v=%0b res=%0d words=%0d, want 1/%0d/1", name, out_valid, out_res, out_words, exp_res);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got out_valid=%0b, want 0", name, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [5];
        logic        lasts [5];
        words = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        lasts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = words[i]; in_last = lasts[i];
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready[%0d]: got %0b, want 1", i, in_ready);
            end
            tick();
            if (i == 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_res !== 3'd1 || out_words !== 16'd2) begin
                    n_fail++;
                    $display("FAIL b2b_msg1: got v=%0b res=%0d words=%0d, want 1/1/2", out_valid, out_res, out_words);
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 3'd3 || out_words !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_msg2: got v=%0b res=%0d words=%0d, want 1/3/3", out_valid, out_res, out_words);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd9; in_last = 1'b1;
        tick();
        in_data = 32'd13;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got v=%0b res=%0d in_ready=%0b, want 1/4/0", out_valid, out_res, in_ready);
        end
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 3'd4 || out_words !== 16'd1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%0b res=%0d words=%0d in_ready=%0b, want 1/4/1/0", out_valid, out_res, out_words, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 3'd3 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_replace: got v=%0b res=%0d in_ready=%0b, want 1/3/1", out_valid, out_res, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_hold2: got v=%0b res=%0d, want 1/3", out_valid, out_res);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_message();
        // Leave a pending result, then two non-last words of a 4-word message
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1;
        tick();
        in_data = 32'd1; in_last = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_res !== 3'd0 || out_words !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b res=%0d words=%0d in_ready=%0b, want 0/0/0/1", out_valid, out_res, out_words, in_ready);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        test_single_word(32'h0000_000A, 3'd0, "post_reset");
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1; s_in_data = 32'd1; s_in_last = (i == 4);
            tick();
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        tick();
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_res !== 3'd0 || s_out_words !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_words: got v=%0b res=%0d words=%0d, want 1/0/3", s_out_valid, s_out_res, s_out_words);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'd0; s_in_last = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_single_word(32'h0000_0007, 3'd2, "word7");
        test_single_word(32'hFFFF_FFFF, 3'd0, "wordF");
        test_back_to_back();
        test_backpressure();
        test_reset_mid_message();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
